// File: rtl/bus_defs.sv
// Shared bus definitions for the program loader and its bus peers.
//   WRITE_CODE / IDLE_CODE : control codes driven on the slave control lines
//   state_t                : loader FSM state encoding
package bus_defs;

  localparam logic [7:0] WRITE_CODE = 8'hFE;
  localparam logic [7:0] IDLE_CODE  = 8'hFF;

  typedef enum logic [2:0] {
    ST_IDLE    = 3'd0,
    ST_REQ     = 3'd1,
    ST_ADDR    = 3'd2,
    ST_DATA    = 3'd3,
    ST_RELEASE = 3'd4,
    ST_DONE    = 3'd5
  } state_t;

endpackage

// File: rtl/prog_loader.sv
// Program loader: accepts program words from a valid/ready source and writes
// each one to consecutive word addresses over an arbitrated shared bus
// (address phase, then data phase). The CPU is held in reset until the word
// flagged as last has been written; afterwards the loader parks in DONE.
//
// Ports
//   clk          : system clock, rising edge
//   reset        : asynchronous active-high reset
//   load_valid   : source word available
//   load_data    : source word
//   load_last    : load_data is the final program word
//   load_ready   : loader accepts a word this cycle
//   bus_req      : bus ownership request to the arbiter
//   bus_ack      : grant; loader owns the bus while high
//   bus_ctrl_out : control code to the slave (WRITE_CODE / IDLE_CODE)
//   bus_data_out : address in the address phase, word in the data phase
//   cpu_reset    : high until the program is fully loaded
//   done         : load complete, sticky until reset
module prog_loader #(
  parameter int unsigned            BUS_WIDTH  = 32,
  parameter int unsigned            CTRL_WIDTH = 8,
  parameter logic [BUS_WIDTH-1:0]   BASE_ADDR  = '0,
  parameter logic [CTRL_WIDTH-1:0]  WRITE_CODE = bus_defs::WRITE_CODE,
  parameter logic [CTRL_WIDTH-1:0]  IDLE_CODE  = bus_defs::IDLE_CODE
) (
  input  logic                  clk,
  input  logic                  reset,
  input  logic                  load_valid,
  input  logic [BUS_WIDTH-1:0]  load_data,
  input  logic                  load_last,
  output logic                  load_ready,
  output logic                  bus_req,
  input  logic                  bus_ack,
  output logic [CTRL_WIDTH-1:0] bus_ctrl_out,
  output logic [BUS_WIDTH-1:0]  bus_data_out,
  output logic                  cpu_reset,
  output logic                  done
);

  bus_defs::state_t state, state_nxt;

  logic [BUS_WIDTH-1:0] addr;
  logic [BUS_WIDTH-1:0] hold_data;
  logic                 hold_last;
  logic                 accept;

  assign accept = load_valid && load_ready;

  // Next-state logic. Losing the grant in either bus phase sends the FSM
  // back to REQ with address and held word untouched, so the same write is
  // retried once the arbiter grants again.
  always_comb begin
    state_nxt = state;
    case (state)
      bus_defs::ST_IDLE:    if (accept)  state_nxt = bus_defs::ST_REQ;
      bus_defs::ST_REQ:     if (bus_ack) state_nxt = bus_defs::ST_ADDR;
      bus_defs::ST_ADDR:    state_nxt = bus_ack ? bus_defs::ST_DATA    : bus_defs::ST_REQ;
      bus_defs::ST_DATA:    state_nxt = bus_ack ? bus_defs::ST_RELEASE : bus_defs::ST_REQ;
      bus_defs::ST_RELEASE: state_nxt = hold_last ? bus_defs::ST_DONE : bus_defs::ST_IDLE;
      bus_defs::ST_DONE:    state_nxt = bus_defs::ST_DONE;
      default:              state_nxt = bus_defs::ST_IDLE;
    endcase
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state <= bus_defs::ST_IDLE;
    end else begin
      state <= state_nxt;
    end
  end

  // Word address advances only after a completed data phase; it wraps
  // naturally at 2^BUS_WIDTH.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      addr <= BASE_ADDR;
    end else if (state == bus_defs::ST_RELEASE) begin
      addr <= addr + BUS_WIDTH'(1);
    end
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      hold_data <= '0;
      hold_last <= 1'b0;
    end else if (accept) begin
      hold_data <= load_data;
      hold_last <= load_last;
    end
  end

  // Outputs decode from state. The write code is gated with bus_ack so an
  // aborted phase drives the idle code in the very cycle the grant is lost.
  always_comb begin
    bus_ctrl_out = IDLE_CODE;
    bus_data_out = '0;
    if (bus_ack) begin
      if (state == bus_defs::ST_ADDR) begin
        bus_ctrl_out = WRITE_CODE;
        bus_data_out = addr;
      end else if (state == bus_defs::ST_DATA) begin
        bus_ctrl_out = WRITE_CODE;
        bus_data_out = hold_data;
      end
    end
  end

  assign bus_req    = (state == bus_defs::ST_REQ)  ||
                      (state == bus_defs::ST_ADDR) ||
                      (state == bus_defs::ST_DATA);
  // Reset forces the state to IDLE; ready is masked so nothing is accepted
  // while reset is still asserted.
  assign load_ready = (state == bus_defs::ST_IDLE) && !reset;
  assign cpu_reset  = (state != bus_defs::ST_DONE);
  assign done       = (state == bus_defs::ST_DONE);

endmodule

// File: tb/tb_prog_loader.sv
// Directed self-checking bench for prog_loader.
module tb_prog_loader;

  logic        clk = 1'b0;
  logic        reset;
  logic        load_valid;
  logic [31:0] load_data;
  logic        load_last;
  logic        load_ready;
  logic        bus_req;
  logic        bus_ack;
  logic [7:0]  bus_ctrl_out;
  logic [31:0] bus_data_out;
  logic        cpu_reset;
  logic        done;

  localparam logic [7:0] WR = 8'hFE;
  localparam logic [7:0] ID = 8'hFF;
  localparam logic [31:0] W0 = 32'h2008_0005;
  localparam logic [31:0] W1 = 32'h201D_1050;
  localparam logic [31:0] W2 = 32'hAFA8_0000;

  prog_loader #(
    .BUS_WIDTH (32),
    .CTRL_WIDTH(8),
    .BASE_ADDR (32'h0),
    .WRITE_CODE(8'hFE),
    .IDLE_CODE (8'hFF)
  ) dut (
    .clk         (clk),
    .reset       (reset),
    .load_valid  (load_valid),
    .load_data   (load_data),
    .load_last   (load_last),
    .load_ready  (load_ready),
    .bus_req     (bus_req),
    .bus_ack     (bus_ack),
    .bus_ctrl_out(bus_ctrl_out),
    .bus_data_out(bus_data_out),
    .cpu_reset   (cpu_reset),
    .done        (done)
  );

  always #5 clk = ~clk;

  int unsigned n_checks = 0;
  int unsigned n_errors = 0;
  int unsigned cyc = 0;

  always @(posedge clk) cyc++;

  // Bus write log: an address-phase write code followed directly by a
  // data-phase write code is one completed write.
  logic [31:0] wr_addr[$];
  logic [31:0] wr_data[$];
  logic        mon_phase = 1'b0;
  logic [31:0] mon_addr;

  always @(negedge clk) begin
    if (reset) begin
      mon_phase = 1'b0;
    end else if (bus_ctrl_out == WR) begin
      if (!mon_phase) begin
        mon_addr  = bus_data_out;
        mon_phase = 1'b1;
      end else begin
        wr_addr.push_back(mon_addr);
        wr_data.push_back(bus_data_out);
        mon_phase = 1'b0;
      end
    end else begin
      mon_phase = 1'b0;
    end
  end

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_errors++;
      $display("FAIL %s: got %h expected %h", tag, got, exp);
    end
  endtask

  function automatic logic [31:0] log_addr(input int i);
    return (i < wr_addr.size()) ? wr_addr[i] : 32'hxxxx_xxxx;
  endfunction

  function automatic logic [31:0] log_data(input int i);
    return (i < wr_data.size()) ? wr_data[i] : 32'hxxxx_xxxx;
  endfunction

  task automatic do_reset();
    reset      = 1'b1;
    load_valid = 1'b0;
    load_data  = '0;
    load_last  = 1'b0;
    bus_ack    = 1'b0;
    @(negedge clk);
    @(posedge clk);
    #1 reset = 1'b0;
    wr_addr.delete();
    wr_data.delete();
  endtask

  // Presents a word and returns just after the accepting edge.
  task automatic push_word(input logic [31:0] d, input logic last, input bit keep,
                           output int unsigned acc_cyc, output int unsigned wait_cyc);
    bit got;
    got        = 1'b0;
    wait_cyc   = 0;
    load_valid = 1'b1;
    load_data  = d;
    load_last  = last;
    for (int i = 0; i < 50; i++) begin
      @(negedge clk);
      if (load_ready) begin
        got = 1'b1;
        break;
      end
      wait_cyc++;
    end
    if (!got) check("accept_timeout", 32'(got), 32'd1);
    @(posedge clk);
    #1;
    acc_cyc = cyc;
    if (!keep) load_valid = 1'b0;
  endtask

  task automatic wait_done();
    bit ok;
    ok = 1'b0;
    for (int i = 0; i < 50; i++) begin
      @(negedge clk);
      if (done) begin
        ok = 1'b1;
        break;
      end
    end
    check("done_reached", 32'(ok), 32'd1);
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog: got timeout expected finish");
    $fatal(1, "watchdog");
  end

  initial begin
    int unsigned a0, a1, a2, t0, t1, t2;
    int unsigned n_rdy, n_bus;

    // ---- reset values, then three-word stream with immediate grant ----
    reset = 1'b1; load_valid = 1'b0; load_data = '0; load_last = 1'b0; bus_ack = 1'b0;
    @(negedge clk);
    check("rst_load_ready", 32'(load_ready), 32'd0);
    check("rst_bus_req",    32'(bus_req),    32'd0);
    check("rst_ctrl",       32'(bus_ctrl_out), 32'(ID));
    check("rst_data",       bus_data_out,    32'd0);
    check("rst_cpu_reset",  32'(cpu_reset),  32'd1);
    check("rst_done",       32'(done),       32'd0);
    @(posedge clk);
    #1 reset = 1'b0;
    wr_addr.delete(); wr_data.delete();

    bus_ack = 1'b1;
    push_word(W0, 1'b0, 1'b1, a0, t0);
    push_word(W1, 1'b0, 1'b1, a1, t1);
    push_word(W2, 1'b1, 1'b0, a2, t2);
    check("stream_first_wait", t0, 32'd0);
    check("stream_gap1",       a1 - a0, 32'd5);
    check("stream_notready1",  t1, 32'd4);
    check("stream_gap2",       a2 - a1, 32'd5);
    check("stream_notready2",  t2, 32'd4);
    wait_done();
    check("fin_cpu_reset",  32'(cpu_reset),  32'd0);
    check("fin_load_ready", 32'(load_ready), 32'd0);
    check("log_size3",      32'(wr_addr.size()), 32'd3);
    check("wr0_addr", log_addr(0), 32'd0); check("wr0_data", log_data(0), W0);
    check("wr1_addr", log_addr(1), 32'd1); check("wr1_data", log_data(1), W1);
    check("wr2_addr", log_addr(2), 32'd2); check("wr2_data", log_data(2), W2);

    // ---- load_valid after DONE is ignored ----
    load_valid = 1'b1; load_data = 32'hDEAD_BEEF; load_last = 1'b1;
    n_rdy = 0; n_bus = 0;
    for (int i = 0; i < 10; i++) begin
      @(negedge clk);
      if (load_ready) n_rdy++;
      if (bus_req || bus_ctrl_out != ID || bus_data_out != 32'd0) n_bus++;
    end
    load_valid = 1'b0;
    check("post_done_ready", n_rdy, 32'd0);
    check("post_done_bus",   n_bus, 32'd0);
    check("post_done_log",   32'(wr_addr.size()), 32'd3);
    check("post_done_done",  32'(done), 32'd1);

    // ---- grant delayed four cycles ----
    do_reset();
    push_word(32'h1111_1111, 1'b1, 1'b0, a0, t0);
    for (int i = 0; i < 4; i++) begin
      @(negedge clk);
      check("grant_wait_req",  32'(bus_req), 32'd1);
      check("grant_wait_ctrl", 32'(bus_ctrl_out), 32'(ID));
    end
    @(posedge clk);
    #1 bus_ack = 1'b1;
    @(negedge clk);
    check("grant_req_hold", 32'(bus_req), 32'd1);
    check("grant_req_ctrl", 32'(bus_ctrl_out), 32'(ID));
    @(negedge clk);
    check("grant_addr_ctrl", 32'(bus_ctrl_out), 32'(WR));
    check("grant_addr_val",  bus_data_out, 32'd0);
    @(negedge clk);
    check("grant_data_ctrl", 32'(bus_ctrl_out), 32'(WR));
    check("grant_data_val",  bus_data_out, 32'h1111_1111);
    check("grant_data_req",  32'(bus_req), 32'd1);
    @(negedge clk);
    check("grant_rel_req",  32'(bus_req), 32'd0);
    check("grant_rel_ctrl", 32'(bus_ctrl_out), 32'(ID));
    @(negedge clk);
    check("grant_done",     32'(done), 32'd1);
    check("grant_cpu_rst",  32'(cpu_reset), 32'd0);

    // ---- grant lost during DATA of the word at address 1 ----
    do_reset();
    bus_ack = 1'b1;
    push_word(W0, 1'b0, 1'b0, a0, t0);
    push_word(W1, 1'b0, 1'b0, a1, t1);
    @(negedge clk);
    @(posedge clk);
    @(negedge clk);
    check("abort_pre_addr", bus_data_out, 32'd1);
    @(posedge clk);
    #1 bus_ack = 1'b0;
    @(negedge clk);
    check("abort_ctrl", 32'(bus_ctrl_out), 32'(ID));
    check("abort_data", bus_data_out, 32'd0);
    check("abort_req",  32'(bus_req), 32'd1);
    @(posedge clk);
    @(negedge clk);
    check("abort_rereq",      32'(bus_req), 32'd1);
    check("abort_rereq_ctrl", 32'(bus_ctrl_out), 32'(ID));
    @(posedge clk);
    #1 bus_ack = 1'b1;
    @(negedge clk);
    @(posedge clk);
    @(negedge clk);
    check("retry_addr_ctrl", 32'(bus_ctrl_out), 32'(WR));
    check("retry_addr",      bus_data_out, 32'd1);
    @(negedge clk);
    check("retry_data", bus_data_out, W1);
    push_word(W2, 1'b1, 1'b0, a2, t2);
    wait_done();
    check("abort_log_size", 32'(wr_addr.size()), 32'd3);
    check("abort_wr0", log_addr(0), 32'd0); check("abort_wd0", log_data(0), W0);
    check("abort_wr1", log_addr(1), 32'd1); check("abort_wd1", log_data(1), W1);
    check("abort_wr2", log_addr(2), 32'd2); check("abort_wd2", log_data(2), W2);

    // ---- reset pulsed during ADDR of the second word ----
    do_reset();
    bus_ack = 1'b1;
    push_word(W0, 1'b0, 1'b0, a0, t0);
    push_word(W1, 1'b0, 1'b0, a1, t1);
    @(negedge clk);
    @(posedge clk);
    #2;
    check("mid_addr_ctrl", 32'(bus_ctrl_out), 32'(WR));
    reset = 1'b1;
    #1;
    check("async_bus_req",    32'(bus_req), 32'd0);
    check("async_ctrl",       32'(bus_ctrl_out), 32'(ID));
    check("async_data",       bus_data_out, 32'd0);
    check("async_load_ready", 32'(load_ready), 32'd0);
    check("async_cpu_reset",  32'(cpu_reset), 32'd1);
    @(posedge clk);
    #1 reset = 1'b0;
    push_word(W2, 1'b1, 1'b0, a2, t2);
    wait_done();
    check("rst_log_size", 32'(wr_addr.size()), 32'd2);
    check("rst_wr0", log_addr(0), 32'd0); check("rst_wd0", log_data(0), W0);
    check("rst_wr1", log_addr(1), 32'd0); check("rst_wd1", log_data(1), W2);

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule
